// File: rtl/led_blink_arbiter.sv
// Round-robin owner of a single board LED: grants it to one requester at a
// time and plays that requester's burst of blinks, then a quiet gap.
module led_blink_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4,
    parameter int T_ON  = 5_000_000,
    parameter int T_OFF = 5_000_000,
    parameter int T_GAP = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] count,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   led
);

    localparam int T_MAX0 = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int T_MAX  = (T_MAX0 > T_GAP) ? T_MAX0 : T_GAP;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int PW     = $clog2(N_REQ);

    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(T_GAP - 1);
    localparam logic [PW:0]   N_WRAP   = (PW+1)'(N_REQ);
    localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic               led_q, led_d;

    logic               win_valid;
    logic [PW-1:0]      win_idx;
    logic [CNT_W-1:0]   win_cnt;
    logic [PW:0]        scan_sum;
    logic [N_REQ-1:0]   owner_oh;

    // Rotating priority search: start at rr_ptr and wrap modulo N_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_sum >= N_WRAP) begin
                scan_sum = scan_sum - N_WRAP;
            end
            if (!win_valid && req[scan_sum[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = scan_sum[PW-1:0];
            end
        end
    end

    assign win_cnt = count[int'(win_idx)*CNT_W +: CNT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            rem_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rem_q    <= rem_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rem_d    = rem_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = win_idx;
                    rem_d   = win_cnt;
                    timer_d = '0;
                    state_d = (win_cnt != '0) ? ON : GAP;
                end
            end
            ON: begin
                if (timer_q == ON_LAST) begin
                    rem_d   = rem_q - CNT_W'(1);
                    timer_d = '0;
                    state_d = (rem_q == CNT_W'(1)) ? GAP : OFF;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    state_d = ON;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d  = '0;
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == LAST_REQ) ? '0 : owner_q + PW'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops
    // on the same edge as the state they describe.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_d] = 1'b1;
        busy_d            = (state_d != IDLE);
        led_d             = (state_d == ON);
        grant_d           = busy_d ? owner_oh : '0;
        done_d            = '0;
        if (state_d == GAP && timer_d == GAP_LAST) begin
            done_d = owner_oh;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Randomised and directed bench for led_blink_arbiter, compared every cycle
// against a burst-level model (owner, position in burst, rotation pointer).
module tb_led_blink_arbiter;

    localparam int NR  = 4;
    localparam int CW  = 4;
    localparam int TON = 3;
    localparam int TOF = 2;
    localparam int TG  = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*CW-1:0] count;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;
    logic            led;

    int n_chk  = 0;
    int n_pass = 0;

    led_blink_arbiter #(
        .N_REQ(NR),
        .CNT_W(CW),
        .T_ON (TON),
        .T_OFF(TOF),
        .T_GAP(TG)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .count(count),
        .grant(grant),
        .done (done),
        .busy (busy),
        .led  (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        int owner;
        int pos;
        int n;
        int rr;
    } mdl_t;

    mdl_t m;

    function automatic int blen(input int n);
        if (n == 0) return TG;
        return n*TON + (n-1)*TOF + TG;
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic [NR-1:0] r,
                                  input logic [NR*CW-1:0] c);
        mdl_t t;
        t = s;
        if (s.busy) begin
            t.pos = s.pos + 1;
            if (t.pos == blen(s.n)) begin
                t.busy = 1'b0;
                t.rr   = (s.owner + 1) % NR;
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (s.rr + k) % NR;
                if (!t.busy && r[i]) begin
                    t.busy  = 1'b1;
                    t.owner = i;
                    t.n     = int'(c[i*CW +: CW]);
                    t.pos   = 0;
                end
            end
        end
        return t;
    endfunction

    function automatic logic [NR-1:0] e_grant(input mdl_t s);
        return s.busy ? NR'(1 << s.owner) : '0;
    endfunction

    function automatic logic [NR-1:0] e_done(input mdl_t s);
        return (s.busy && s.pos == blen(s.n) - 1) ? NR'(1 << s.owner) : '0;
    endfunction

    function automatic logic e_led(input mdl_t s);
        return s.busy && (s.pos < blen(s.n) - TG) &&
               ((s.pos % (TON + TOF)) < TON);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{busy: 1'b0, owner: 0, pos: 0, n: 0, rr: 0};
        else     m <= step(m, req, count);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("grant", 32'(grant), 32'(e_grant(m)));
            chk("done",  32'(done),  32'(e_done(m)));
            chk("busy",  32'(busy),  32'(m.busy));
            chk("led",   32'(led),   32'(e_led(m)));
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_wait();
        int c;
        c = 0;
        req = '0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("idle_wait", 32'(busy), 0);
        @(negedge clk);
    endtask

    task automatic measure(input logic [NR-1:0] g, input bit mid,
                           output int glen, output int pulses,
                           output int badw, output int dones);
        int c;
        int w;
        bit prev;
        bit changed;
        c = 0; w = 0; prev = 0; changed = 0;
        glen = 0; pulses = 0; badw = 0; dones = 0;
        while (grant !== g && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("start_grant", 32'(grant), 32'(g));
        while (grant === g && glen < 400) begin
            glen++;
            if (done === g) dones++;
            if (led) begin
                w++;
            end else if (prev) begin
                pulses++;
                if (w != TON) badw++;
                w = 0;
                if (mid && !changed) begin
                    req[0]     = 1'b0;
                    count[3:0] = 4'd1;
                    changed    = 1'b1;
                end
            end
            prev = led;
            @(negedge clk);
        end
    endtask

    logic [NR-1:0] rr_exp [5];
    logic [NR-1:0] rr_got [5];

    initial begin
        int c;
        int nrec;
        int idle;
        logic [NR-1:0] prevg;
        logic [11:0] ledseq;
        logic [11:0] doneseq;
        int gok;
        int glen, pulses, badw, dones;

        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst   = 1'b1;
        req   = '0;
        count = '0;
        repeat (2) @(negedge clk);
        chk("reset_out", 32'({grant, done, busy, led}), 0);
        rst = 1'b0;

        // async reset in the middle of an ON phase
        @(negedge clk);
        req   = 4'b0001;
        count = 16'h0003;
        c = 0;
        while (led !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("t1_on", 32'(led), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("t1_async", 32'({grant, done, busy, led}), 0);
        req   = 4'b1001;
        count = 16'h1001;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (grant === '0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("t1_first", 32'(grant), 32'(4'b0001));
        idle_wait();

        // round robin with all requesters held
        reset_dut();
        req   = 4'b1111;
        count = 16'h1111;
        nrec = 0; idle = 0; prevg = '0; c = 0;
        for (int k = 0; k < 5; k++) rr_got[k] = '0;
        while (nrec < 5 && c < 300) begin
            @(negedge clk);
            c++;
            if (grant != '0 && prevg == '0) begin
                if (nrec > 0) chk("rr_gap", 32'(idle), 1);
                rr_got[nrec] = grant;
                nrec++;
                idle = 0;
            end else if (grant == '0 && nrec > 0) begin
                idle++;
            end
            prevg = grant;
        end
        req = '0;
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(rr_got[k]), 32'(rr_exp[k]));
        idle_wait();

        // single burst, exact cycle pattern
        @(posedge clk);
        @(negedge clk);
        req   = 4'b0100;
        count = 16'h0200;
        ledseq = '0; doneseq = '0; gok = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req = '0;
            ledseq  = {ledseq[10:0], led};
            doneseq = {doneseq[10:0], (done != '0)};
            if (grant === 4'b0100) gok++;
            if (k == 12) chk("t2_done12", 32'(done), 32'(4'b0100));
        end
        chk("t2_led", 32'(ledseq), 32'(12'b111001110000));
        chk("t2_doneseq", 32'(doneseq), 32'(12'b000000000001));
        chk("t2_grant", 32'(gok), 12);
        @(negedge clk);
        chk("t2_release", 32'(grant), 0);
        idle_wait();

        // zero count burst
        req   = 4'b0010;
        count = 16'h0000;
        measure(4'b0010, 1'b0, glen, pulses, badw, dones);
        req = '0;
        chk("t4_len", 32'(glen), 4);
        chk("t4_pulses", 32'(pulses), 0);
        chk("t4_done", 32'(dones), 1);
        idle_wait();

        // req dropped and count changed during OFF
        req   = 4'b0001;
        count = 16'h0003;
        measure(4'b0001, 1'b1, glen, pulses, badw, dones);
        chk("t5_pulses", 32'(pulses), 3);
        chk("t5_len", 32'(glen), 17);
        chk("t5_done", 32'(dones), 1);
        idle_wait();

        // maximum count
        req   = 4'b1000;
        count = 16'hF000;
        measure(4'b1000, 1'b0, glen, pulses, badw, dones);
        req = '0;
        chk("t6_len", 32'(glen), 77);
        chk("t6_pulses", 32'(pulses), 15);
        chk("t6_width", 32'(badw), 0);
        chk("t6_done", 32'(dones), 1);
        idle_wait();

        // random traffic with occasional asynchronous reset pulses
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NR; i++) begin
                    if ($urandom_range(0, 5) == 0)
                        count[i*CW +: CW] = 4'($urandom_range(0, 15));
                    else
                        count[i*CW +: CW] = 4'($urandom_range(0, 3));
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        idle_wait();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
